// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: coordinates, sync/blank, line/frame strobes.
// Define VGA_FRAME_COUNT_EN to build the 16-bit frame counter; otherwise FrameCount is tied to 0.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int PIPE_DLY = 0,
  parameter int CW       = 10
) (
  input  logic          VGA_CLK,
  input  logic          Reset,
  input  logic          Enable,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK_N,
  output logic          VGA_SYNC_N,
  output logic [CW-1:0] DrawX,
  output logic [CW-1:0] DrawY,
  output logic          LineStart,
  output logic          FrameStart,
  output logic [15:0]   FrameCount
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_LAST = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] HS_FIRST   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST    = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT_LAST = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] VS_FIRST   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST    = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic       HS_ON = (HS_POL != 0);
  localparam logic       VS_ON = (VS_POL != 0);
  // Stage layout is {hs, vs, blank_n}; IDLE is the inactive/reset pattern.
  localparam logic [2:0] IDLE  = {~HS_ON, ~VS_ON, 1'b0};
  localparam int         PW    = 3 * (PIPE_DLY + 1);

  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic          h_wrap, v_wrap;
  logic          hs_act, vs_act, active;
  logic [2:0]    align_d;
  logic [PW-1:0] pipe_q, pipe_d;

  assign h_wrap = (h_q == H_LAST);
  assign v_wrap = (v_q == V_LAST);

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (Enable) begin
      if (h_wrap) begin
        h_d = '0;
        v_d = v_wrap ? '0 : v_q + CW'(1);
      end else begin
        h_d = h_q + CW'(1);
      end
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (Reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Decoding the next counter values lets the registered flags line up with DrawX/DrawY.
  assign hs_act  = (h_d >= HS_FIRST) && (h_d <= HS_LAST);
  assign vs_act  = (v_d >= VS_FIRST) && (v_d <= VS_LAST);
  assign active  = (h_d <= H_ACT_LAST) && (v_d <= V_ACT_LAST);
  assign align_d = {hs_act ? HS_ON : ~HS_ON, vs_act ? VS_ON : ~VS_ON, active};

  // Stage 0 is the alignment register; higher stages form the PIPE_DLY delay line.
  if (PIPE_DLY == 0) begin : g_nodly
    assign pipe_d = align_d;
  end else begin : g_dly
    assign pipe_d = {pipe_q[PW-4:0], align_d};
  end

  always_ff @(posedge VGA_CLK) begin
    if (Reset) begin
      pipe_q <= {(PIPE_DLY + 1){IDLE}};
    end else if (Enable) begin
      pipe_q <= pipe_d;
    end
  end

  assign {VGA_HS, VGA_VS, VGA_BLANK_N} = pipe_q[PW-1 -: 3];
  assign VGA_SYNC_N = 1'b0;
  assign DrawX      = h_q;
  assign DrawY      = v_q;
  assign LineStart  = Enable && !Reset && (h_q == '0);
  assign FrameStart = Enable && !Reset && (h_q == '0) && (v_q == '0);

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_q;

  always_ff @(posedge VGA_CLK) begin
    if (Reset) begin
      frame_q <= '0;
    end else if (Enable && h_wrap && v_wrap) begin
      frame_q <= frame_q + 16'd1;
    end
  end

  assign FrameCount = frame_q;
`else
  assign FrameCount = '0;
`endif

  always_ff @(posedge VGA_CLK) begin
    assert ((H_TOTAL <= (1 << CW)) && (V_TOTAL <= (1 << CW)) && (PIPE_DLY >= 0) && (PIPE_DLY <= 7))
      else $error("vga_timing_gen: bad parameters H_TOTAL=%0d V_TOTAL=%0d CW=%0d PIPE_DLY=%0d",
                  H_TOTAL, V_TOTAL, CW, PIPE_DLY);
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480, delayed 640x480, 800x600 and a tiny mode
// used for frame-level behaviour within a short run.
module tb_vga_timing_gen;

`ifdef VGA_FRAME_COUNT_EN
  localparam int FC1 = 1;
  localparam int FC2 = 2;
`else
  localparam int FC1 = 0;
  localparam int FC2 = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        d_hs, d_vs, d_bl, d_sy, d_ls, d_fs;
  logic [9:0]  d_x, d_y;
  logic [15:0] d_fc;
  logic        p_hs, p_vs, p_bl, p_sy, p_ls, p_fs;
  logic [9:0]  p_x, p_y;
  logic [15:0] p_fc;
  logic        s_hs, s_vs, s_bl, s_sy, s_ls, s_fs;
  logic [10:0] s_x, s_y;
  logic [15:0] s_fc;
  logic        m_hs, m_vs, m_bl, m_sy, m_ls, m_fs;
  logic [3:0]  m_x, m_y;
  logic [15:0] m_fc;

  vga_timing_gen u_def (
    .VGA_CLK(clk), .Reset(rst), .Enable(en),
    .VGA_HS(d_hs), .VGA_VS(d_vs), .VGA_BLANK_N(d_bl), .VGA_SYNC_N(d_sy),
    .DrawX(d_x), .DrawY(d_y), .LineStart(d_ls), .FrameStart(d_fs), .FrameCount(d_fc)
  );

  vga_timing_gen #(.PIPE_DLY(3)) u_dly (
    .VGA_CLK(clk), .Reset(rst), .Enable(en),
    .VGA_HS(p_hs), .VGA_VS(p_vs), .VGA_BLANK_N(p_bl), .VGA_SYNC_N(p_sy),
    .DrawX(p_x), .DrawY(p_y), .LineStart(p_ls), .FrameStart(p_fs), .FrameCount(p_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
    .HS_POL(1), .VS_POL(1), .CW(11)
  ) u_svga (
    .VGA_CLK(clk), .Reset(rst), .Enable(en),
    .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_BLANK_N(s_bl), .VGA_SYNC_N(s_sy),
    .DrawX(s_x), .DrawY(s_y), .LineStart(s_ls), .FrameStart(s_fs), .FrameCount(s_fc)
  );

  // Tiny mode: H_TOTAL=14 (sync x 10..12), V_TOTAL=8 (sync y 5..6), 112 cycles per frame.
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CW(4)
  ) u_sm (
    .VGA_CLK(clk), .Reset(rst), .Enable(en),
    .VGA_HS(m_hs), .VGA_VS(m_vs), .VGA_BLANK_N(m_bl), .VGA_SYNC_N(m_sy),
    .DrawX(m_x), .DrawY(m_y), .LineStart(m_ls), .FrameStart(m_fs), .FrameCount(m_fc)
  );

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++; if (d_x !== 10'd0) begin errors++; $display("FAIL rst_drawx got %0d want 0", d_x); end
      checks++; if (d_y !== 10'd0) begin errors++; $display("FAIL rst_drawy got %0d want 0", d_y); end
      checks++; if (d_hs !== 1'b1) begin errors++; $display("FAIL rst_hs got %b want 1", d_hs); end
      checks++; if (d_vs !== 1'b1) begin errors++; $display("FAIL rst_vs got %b want 1", d_vs); end
      checks++; if (d_bl !== 1'b0) begin errors++; $display("FAIL rst_blank got %b want 0", d_bl); end
      checks++; if (d_sy !== 1'b0) begin errors++; $display("FAIL rst_sync_n got %b want 0", d_sy); end
      checks++; if (d_ls !== 1'b0) begin errors++; $display("FAIL rst_linestart got %b want 0", d_ls); end
      checks++; if (d_fs !== 1'b0) begin errors++; $display("FAIL rst_framestart got %b want 0", d_fs); end
      checks++; if (d_fc !== 16'd0) begin errors++; $display("FAIL rst_framecount got %0d want 0", d_fc); end
      checks++; if (p_hs !== 1'b1 || p_bl !== 1'b0) begin errors++; $display("FAIL rst_dly_hs_blank got %b%b want 10", p_hs, p_bl); end
      checks++; if (s_hs !== 1'b0 || s_vs !== 1'b0) begin errors++; $display("FAIL rst_svga_hs_vs got %b%b want 00", s_hs, s_vs); end
    end
  endtask

  task automatic test_horizontal();
    int d_hs_n = 0, d_hs_first = -1, d_hs_last = -1, bl0 = 0, bl1 = 0, ls_n = 0, fs_n = 0;
    int x799 = -1, x800 = -1, y800 = -1;
    int p_hs_n = 0, p_hs_first = -1, p_hs_last = -1, p_bl_first = -1, p_bl_last = -1;
    int s_hs_n = 0, s_hs_first = -1, s_hs_last = -1, s_bl0 = 0, s_x1055 = -1, s_x1056 = -1, s_y1056 = -1;
    apply_reset();
    for (int k = 0; k < 1701; k++) begin
      #1;
      if (k < 800 && d_hs == 1'b0) begin
        d_hs_n++;
        if (d_hs_first < 0) d_hs_first = int'(d_x);
        d_hs_last = int'(d_x);
      end
      if (k < 800 && d_bl) bl0++;
      if (k >= 800 && k < 1600 && d_bl) bl1++;
      if (d_ls) ls_n++;
      if (d_fs) fs_n++;
      if (k == 799) x799 = int'(d_x);
      if (k == 800) begin x800 = int'(d_x); y800 = int'(d_y); end
      if (k < 800 && p_hs == 1'b0) begin
        p_hs_n++;
        if (p_hs_first < 0) p_hs_first = k;
        p_hs_last = k;
      end
      if (k < 800 && p_bl) begin
        if (p_bl_first < 0) p_bl_first = k;
        p_bl_last = k;
      end
      if (k < 1056 && s_hs == 1'b1) begin
        s_hs_n++;
        if (s_hs_first < 0) s_hs_first = int'(s_x);
        s_hs_last = int'(s_x);
      end
      if (k < 1056 && s_bl) s_bl0++;
      if (k == 1055) s_x1055 = int'(s_x);
      if (k == 1056) begin s_x1056 = int'(s_x); s_y1056 = int'(s_y); end
      @(negedge clk);
    end
    checks++; if (d_hs_n != 96) begin errors++; $display("FAIL hs_low_count got %0d want 96", d_hs_n); end
    checks++; if (d_hs_first != 656) begin errors++; $display("FAIL hs_first_x got %0d want 656", d_hs_first); end
    checks++; if (d_hs_last != 751) begin errors++; $display("FAIL hs_last_x got %0d want 751", d_hs_last); end
    checks++; if (bl0 != 639) begin errors++; $display("FAIL blank_line0 got %0d want 639", bl0); end
    checks++; if (bl1 != 640) begin errors++; $display("FAIL blank_line1 got %0d want 640", bl1); end
    checks++; if (ls_n != 3) begin errors++; $display("FAIL linestart_count got %0d want 3", ls_n); end
    checks++; if (fs_n != 1) begin errors++; $display("FAIL framestart_count got %0d want 1", fs_n); end
    checks++; if (x799 != 799) begin errors++; $display("FAIL drawx_799 got %0d want 799", x799); end
    checks++; if (x800 != 0 || y800 != 1) begin errors++; $display("FAIL drawx_wrap got x=%0d y=%0d want x=0 y=1", x800, y800); end
    checks++; if (p_hs_n != 96) begin errors++; $display("FAIL dly_hs_count got %0d want 96", p_hs_n); end
    checks++; if (p_hs_first != 659) begin errors++; $display("FAIL dly_hs_fall got %0d want 659", p_hs_first); end
    checks++; if (p_hs_last != 754) begin errors++; $display("FAIL dly_hs_last got %0d want 754", p_hs_last); end
    checks++; if (p_bl_first != 4) begin errors++; $display("FAIL dly_blank_rise got %0d want 4", p_bl_first); end
    checks++; if (p_bl_last != 642) begin errors++; $display("FAIL dly_blank_last got %0d want 642", p_bl_last); end
    checks++; if (s_hs_n != 128) begin errors++; $display("FAIL svga_hs_count got %0d want 128", s_hs_n); end
    checks++; if (s_hs_first != 840 || s_hs_last != 967) begin errors++; $display("FAIL svga_hs_span got %0d..%0d want 840..967", s_hs_first, s_hs_last); end
    checks++; if (s_bl0 != 799) begin errors++; $display("FAIL svga_blank_line0 got %0d want 799", s_bl0); end
    checks++; if (s_x1055 != 1055) begin errors++; $display("FAIL svga_x1055 got %0d want 1055", s_x1055); end
    checks++; if (s_x1056 != 0 || s_y1056 != 1) begin errors++; $display("FAIL svga_wrap got x=%0d y=%0d want x=0 y=1", s_x1056, s_y1056); end
  endtask

  task automatic test_frame();
    int hs_n = 0, vs_n = 0, vs_y_first = -1, vs_y_last = -1, bl0 = 0, bl1 = 0, ls_n = 0, fs_n = 0, fs_second = -1;
    int x111 = -1, y111 = -1, x112 = -1, y112 = -1, fc112 = -1, fc224 = -1;
    apply_reset();
    for (int k = 0; k < 225; k++) begin
      #1;
      if (k < 14 && m_hs == 1'b0) hs_n++;
      if (k < 112 && m_vs == 1'b0) begin
        vs_n++;
        if (vs_y_first < 0) vs_y_first = int'(m_y);
        vs_y_last = int'(m_y);
      end
      if (k < 112 && m_bl) bl0++;
      if (k >= 112 && k < 224 && m_bl) bl1++;
      if (m_ls) ls_n++;
      if (m_fs) begin
        fs_n++;
        if (fs_n == 2) fs_second = k;
      end
      if (k == 111) begin x111 = int'(m_x); y111 = int'(m_y); end
      if (k == 112) begin x112 = int'(m_x); y112 = int'(m_y); fc112 = int'(m_fc); end
      if (k == 224) fc224 = int'(m_fc);
      @(negedge clk);
    end
    checks++; if (hs_n != 3) begin errors++; $display("FAIL sm_hs_count got %0d want 3", hs_n); end
    checks++; if (vs_n != 28) begin errors++; $display("FAIL sm_vs_count got %0d want 28", vs_n); end
    checks++; if (vs_y_first != 5 || vs_y_last != 6) begin errors++; $display("FAIL sm_vs_span got %0d..%0d want 5..6", vs_y_first, vs_y_last); end
    checks++; if (bl0 != 31) begin errors++; $display("FAIL sm_blank_frame0 got %0d want 31", bl0); end
    checks++; if (bl1 != 32) begin errors++; $display("FAIL sm_blank_frame1 got %0d want 32", bl1); end
    checks++; if (ls_n != 17) begin errors++; $display("FAIL sm_linestart_count got %0d want 17", ls_n); end
    checks++; if (fs_n != 3) begin errors++; $display("FAIL sm_framestart_count got %0d want 3", fs_n); end
    checks++; if (fs_second != 112) begin errors++; $display("FAIL sm_frame_period got %0d want 112", fs_second); end
    checks++; if (x111 != 13 || y111 != 7) begin errors++; $display("FAIL sm_last_pixel got x=%0d y=%0d want x=13 y=7", x111, y111); end
    checks++; if (x112 != 0 || y112 != 0) begin errors++; $display("FAIL sm_frame_wrap got x=%0d y=%0d want x=0 y=0", x112, y112); end
    checks++; if (fc112 != FC1) begin errors++; $display("FAIL sm_framecount_1 got %0d want %0d", fc112, FC1); end
    checks++; if (fc224 != FC2) begin errors++; $display("FAIL sm_framecount_2 got %0d want %0d", fc224, FC2); end
  endtask

  task automatic test_enable_toggle();
    int ls_n = 0, fs_n = 0, fs_second = -1, bad_strobe = 0;
    int x1 = -1, x2 = -1, x3 = -1, x222 = -1, y222 = -1;
    apply_reset();
    for (int k = 0; k < 241; k++) begin
      en = (k % 2 == 0);
      #1;
      if ((m_ls || m_fs) && !en) bad_strobe++;
      if (m_ls) ls_n++;
      if (m_fs) begin
        fs_n++;
        if (fs_n == 2) fs_second = k;
      end
      if (k == 1) x1 = int'(m_x);
      if (k == 2) x2 = int'(m_x);
      if (k == 3) x3 = int'(m_x);
      if (k == 222) begin x222 = int'(m_x); y222 = int'(m_y); end
      @(negedge clk);
    end
    en = 1'b1;
    checks++; if (x1 != 1 || x2 != 1 || x3 != 2) begin errors++; $display("FAIL en_drawx_step got %0d,%0d,%0d want 1,1,2", x1, x2, x3); end
    checks++; if (x222 != 13 || y222 != 7) begin errors++; $display("FAIL en_pos_222 got x=%0d y=%0d want x=13 y=7", x222, y222); end
    checks++; if (bad_strobe != 0) begin errors++; $display("FAIL en_strobe_while_low got %0d want 0", bad_strobe); end
    checks++; if (ls_n != 9) begin errors++; $display("FAIL en_linestart_count got %0d want 9", ls_n); end
    checks++; if (fs_n != 2) begin errors++; $display("FAIL en_framestart_count got %0d want 2", fs_n); end
    checks++; if (fs_second != 224) begin errors++; $display("FAIL en_frame_period got %0d want 224", fs_second); end
  endtask

  task automatic test_reset_midframe();
    apply_reset();
    repeat (300) @(negedge clk);
    #1;
    checks++; if (m_x !== 4'd6 || m_y !== 4'd5) begin errors++; $display("FAIL mid_pos got x=%0d y=%0d want x=6 y=5", m_x, m_y); end
    checks++; if (int'(m_fc) != FC2) begin errors++; $display("FAIL mid_framecount got %0d want %0d", m_fc, FC2); end
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (m_x !== 4'd0 || m_y !== 4'd0) begin errors++; $display("FAIL mid_reset_pos got x=%0d y=%0d want x=0 y=0", m_x, m_y); end
    checks++; if (m_fc !== 16'd0) begin errors++; $display("FAIL mid_reset_framecount got %0d want 0", m_fc); end
    checks++; if (m_hs !== 1'b1 || m_vs !== 1'b1 || m_bl !== 1'b0) begin errors++; $display("FAIL mid_reset_sync got %b%b%b want 110", m_hs, m_vs, m_bl); end
    rst = 1'b0;
    en  = 1'b1;
    repeat (224) @(negedge clk);
    #1;
    checks++; if (m_x !== 4'd0 || m_y !== 4'd0 || m_fs !== 1'b1) begin errors++; $display("FAIL after2_pos got x=%0d y=%0d fs=%b want 0 0 1", m_x, m_y, m_fs); end
    checks++; if (int'(m_fc) != FC2) begin errors++; $display("FAIL after2_framecount got %0d want %0d", m_fc, FC2); end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_frame();
    test_enable_toggle();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
